maxpool_ctrl: RTL and testbench

Sequencer for the 2x2 max-pool stage (layer 1) of the image convolution pipeline. On start it walks the IMG_W x IMG_W layer-0 result memory in 2x2 windows. It loads each window into a 4-entry window register, reduces it to a single maximum, and writes that value to the (IMG_W/2) x (IMG_W/2) layer-1 memory. It sits between the layer-0 buffer read port and the layer-1 buffer write port, under control of the top-level FSM.

---
 rtl/maxpool_ctrl_pkg.sv | 27 ++
 rtl/maxpool_ctrl_if.sv | 27 ++
 rtl/maxpool_ctrl_pool_window.sv | 40 ++++
 rtl/maxpool_ctrl.sv | 125 ++++++++++++
 tb/tb_maxpool_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/maxpool_ctrl_pkg.sv
`default_nettype none
// cnn_pkg -- shared geometry, data width and state encoding for the max-pool sequencer.
// Rev 1.0
package cnn_pkg;

  localparam int IMG_W = 64;
  localparam int DW    = 20;
  localparam int OUT_W = IMG_W / 2;
  localparam int AW0   = $clog2(IMG_W * IMG_W);
  localparam int AW1   = $clog2(OUT_W * OUT_W);
  localparam int OW_LG = $clog2(OUT_W);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_LAT  = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  // Read order inside a window: top-left, top-right, bottom-left, bottom-right.
  localparam logic [AW0-1:0] WIN_OFF [4] = '{
    AW0'(0), AW0'(1), AW0'(IMG_W), AW0'(IMG_W + 1)
  };

endpackage
`default_nettype wire

// File: rtl/maxpool_ctrl_if.sv
`default_nettype none
// maxpool_ctrl_if -- start/status handshake plus layer-0 read and layer-1 write ports.
// Rev 1.0
interface maxpool_ctrl_if;

  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     l0_rd;
  logic [cnn_pkg::AW0-1:0]  l0_addr;
  logic [cnn_pkg::DW-1:0]   l0_rdata;
  logic                     l1_wr;
  logic [cnn_pkg::AW1-1:0]  l1_addr;
  logic [cnn_pkg::DW-1:0]   l1_wdata;

  modport master (
    input  start, l0_rdata,
    output busy, done, l0_rd, l0_addr, l1_wr, l1_addr, l1_wdata
  );

  modport slave (
    output start, l0_rdata,
    input  busy, done, l0_rd, l0_addr, l1_wr, l1_addr, l1_wdata
  );

endinterface
`default_nettype wire

// File: rtl/maxpool_ctrl_pool_window.sv
`default_nettype none
// pool_window -- four-entry 2x2 window register with one-hot load and signed 4-way max.
// Rev 1.0
module pool_window
  import cnn_pkg::*;
(
  input  wire             clk,
  input  wire             rst,
  input  wire [DW-1:0]    din_i,
  input  wire [3:0]       en_i,
  output logic [DW-1:0]   max_o
);

  logic signed [DW-1:0] win_q  [4];
  logic signed [DW-1:0] win_nx [4];
  logic signed [DW-1:0] m01;
  logic signed [DW-1:0] m23;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) win_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (en_i[i]) win_q[i] <= din_i;
      end
    end
  end

  // The tree sees the window as it will stand after this edge, so the last
  // entry's data reaches the registered write data on the same edge it loads.
  always_comb begin
    for (int i = 0; i < 4; i++) win_nx[i] = en_i[i] ? din_i : win_q[i];
  end

  assign m01   = (win_nx[0] > win_nx[1]) ? win_nx[0] : win_nx[1];
  assign m23   = (win_nx[2] > win_nx[3]) ? win_nx[2] : win_nx[3];
  assign max_o = (m01 > m23) ? m01 : m23;

endmodule
`default_nettype wire

// File: rtl/maxpool_ctrl.sv
`default_nettype none
// maxpool_ctrl -- 2x2 max-pool sequencer from layer-0 buffer into layer-1 buffer. Rev 1.0
// Build option MAXPOOL_RELU_EN: clamp negative pooled values to zero before the write.
module maxpool_ctrl
  import cnn_pkg::*;
(
  input  wire              clk,
  input  wire              rst,
  maxpool_ctrl_if.master   bus
);

  localparam logic [AW1-1:0] N_LAST = AW1'(OUT_W * OUT_W - 1);

  state_e          state_q, state_d;
  logic [AW1-1:0]  n_q, n_d;
  logic [1:0]      k_q, k_d;
  logic [3:0]      en_q, en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            l0_rd_q, l0_rd_d;
  logic [AW0-1:0]  l0_addr_q, l0_addr_d;
  logic            l1_wr_q, l1_wr_d;
  logic [AW1-1:0]  l1_addr_q, l1_addr_d;
  logic [DW-1:0]   l1_wdata_q, l1_wdata_d;
  logic [AW0-1:0]  base;
  logic [DW-1:0]   win_max;
  logic [DW-1:0]   pix;

  pool_window u_win (
    .clk   (clk),
    .rst   (rst),
    .din_i (bus.l0_rdata),
    .en_i  (en_q),
    .max_o (win_max)
  );

`ifdef MAXPOOL_RELU_EN
  assign pix = win_max[DW-1] ? '0 : win_max;
`else
  assign pix = win_max;
`endif

  // Top-left pixel of window n: row bits shifted up one image row pair, col doubled.
  assign base = {n_d[AW1-1:OW_LG], 1'b0, n_d[OW_LG-1:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      k_q        <= '0;
      en_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      l0_rd_q    <= 1'b0;
      l0_addr_q  <= '0;
      l1_wr_q    <= 1'b0;
      l1_addr_q  <= '0;
      l1_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      l0_rd_q    <= l0_rd_d;
      l0_addr_q  <= l0_addr_d;
      l1_wr_q    <= l1_wr_d;
      l1_addr_q  <= l1_addr_d;
      l1_wdata_q <= l1_wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RD;
          n_d     = '0;
          k_d     = '0;
        end
      end
      ST_RD: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = ST_LAT;
      end
      ST_LAT: state_d = ST_WR;
      ST_WR: begin
        if (n_q == N_LAST) begin
          state_d = ST_FIN;
        end else begin
          n_d     = n_q + 1'b1;
          state_d = ST_RD;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each registered strobe lines up with its state.
  always_comb begin
    busy_d     = (state_d == ST_RD) || (state_d == ST_LAT) || (state_d == ST_WR);
    done_d     = (state_d == ST_FIN);
    l0_rd_d    = (state_d == ST_RD);
    l0_addr_d  = l0_rd_d ? (base + WIN_OFF[k_d]) : '0;
    l1_wr_d    = (state_d == ST_WR);
    l1_addr_d  = l1_wr_d ? n_d : l1_addr_q;
    l1_wdata_d = l1_wr_d ? pix : l1_wdata_q;
    en_d       = (state_q == ST_RD) ? (4'b0001 << k_q) : 4'b0000;
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.l0_rd    = l0_rd_q;
  assign bus.l0_addr  = l0_addr_q;
  assign bus.l1_wr    = l1_wr_q;
  assign bus.l1_addr  = l1_addr_q;
  assign bus.l1_wdata = l1_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_ctrl.sv
`default_nettype none
// tb_maxpool_ctrl -- directed self-checking bench for the 2x2 max-pool sequencer.
// Rev 1.0
module tb_maxpool_ctrl;

  localparam int IMG_W = 64;
  localparam int DW    = 20;
  localparam int AW0   = 12;
  localparam int HALF  = IMG_W / 2;
  localparam int NPIX  = HALF * HALF;
  localparam int PASS_CYC = NPIX * 6 + 1;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] mem0 [IMG_W*IMG_W];
  logic [DW-1:0] mem1 [NPIX];

  int checks   = 0;
  int failures = 0;
  int rd_idx, addr_err, done_cnt, done_at, overlap, wr_cnt, idle_act;
  logic busy1, busy_done, rst_busy, rst_rd, rst_wr, rst_done;
  logic [AW0-1:0] first_addr, rst_addr;
  logic [AW0-1:0] a33 [4];

  maxpool_ctrl_if bus ();
  assign bus.start    = start;
  assign bus.l0_rdata = rdata;

  maxpool_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Layer-0 memory with one-cycle read latency, layer-1 write-only memory.
  always @(posedge clk) begin
    if (bus.l0_rd) rdata <= mem0[bus.l0_addr];
    if (bus.l1_wr) mem1[bus.l1_addr] <= bus.l1_wdata;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] dw(input int v);
    logic [DW-1:0] t;
    t = DW'(v);
    return 32'(t);
  endfunction

  function automatic int exp_addr(input int idx);
    int n, k;
    n = idx / 4;
    k = idx % 4;
    return (2 * (n / HALF)) * IMG_W + 2 * (n % HALF) + (k / 2) * IMG_W + (k % 2);
  endfunction

  // Pulse start, then observe ncyc cycles; cycle 1 is the one after the start edge.
  task automatic run(input int ncyc, input int mid_at, input int rst_at);
    rd_idx = 0; addr_err = 0; done_cnt = 0; done_at = 0; overlap = 0; wr_cnt = 0;
    busy1 = 1'b0; busy_done = 1'b1; first_addr = '1;
    @(negedge clk);
    start = 1'b1;
    for (int m = 1; m <= ncyc; m++) begin
      @(negedge clk);
      if (bus.l0_rd) begin
        if (rd_idx == 0) first_addr = bus.l0_addr;
        if (int'(bus.l0_addr) != exp_addr(rd_idx)) addr_err++;
        if (rd_idx / 4 == 33) a33[rd_idx % 4] = bus.l0_addr;
        rd_idx++;
      end
      if (bus.l1_wr) wr_cnt++;
      if (bus.l0_rd && bus.l1_wr) overlap++;
      if (bus.done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at   = m;
          busy_done = bus.busy;
        end
      end
      if (m == 1) begin
        busy1 = bus.busy;
        start = 1'b0;
      end
      if (rst_at > 0 && m == rst_at + 1) begin
        rst_busy = bus.busy; rst_rd = bus.l0_rd; rst_wr = bus.l1_wr;
        rst_done = bus.done; rst_addr = bus.l0_addr;
      end
      if (m == mid_at) start = 1'b1;
      if (m == mid_at + 1) start = 1'b0;
      if (rst_at > 0 && m == rst_at) rst = 1'b1;
    end
  endtask

  initial begin
    for (int a = 0; a < IMG_W * IMG_W; a++) mem0[a] = DW'(a);
    repeat (3) @(negedge clk);
    check("rst_busy",     bus.busy,     0);
    check("rst_done",     bus.done,     0);
    check("rst_l0_rd",    bus.l0_rd,    0);
    check("rst_l0_addr",  bus.l0_addr,  0);
    check("rst_l1_wr",    bus.l1_wr,    0);
    check("rst_l1_addr",  bus.l1_addr,  0);
    check("rst_l1_wdata", bus.l1_wdata, 0);
    rst = 1'b0;

    idle_act = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.l0_rd || bus.l1_wr) idle_act++;
    end
    check("idle_quiet", idle_act, 0);

    // Full pass with layer-0 word = address
    run(PASS_CYC + 55, 0, 0);
    check("p1_busy_c1",   busy1,     1);
    check("p1_done_at",   done_at,   6145);
    check("p1_done_once", done_cnt,  1);
    check("p1_busy_done", busy_done, 0);
    check("p1_reads",     rd_idx,    4096);
    check("p1_writes",    wr_cnt,    1024);
    check("p1_addr_seq",  addr_err,  0);
    check("p1_overlap",   overlap,   0);
    check("p1_a33_0",     a33[0],    130);
    check("p1_a33_1",     a33[1],    131);
    check("p1_a33_2",     a33[2],    194);
    check("p1_a33_3",     a33[3],    195);
    check("p1_l1_0",      mem1[0],    dw(65));
    check("p1_l1_33",     mem1[33],   dw(195));
    check("p1_l1_1023",   mem1[1023], dw(4095));

    // Second start pulse during the pass is ignored
    run(PASS_CYC + 55, 200, 0);
    check("p2_done_at",   done_at,  6145);
    check("p2_done_once", done_cnt, 1);
    check("p2_addr_seq",  addr_err, 0);
    check("p2_reads",     rd_idx,   4096);

    // Hand-built windows: largest at W2, W3, W0, W1 in turn
    mem0[0] = DW'(5);    mem0[1] = DW'(-3);   mem0[64] = DW'(12);  mem0[65] = DW'(7);
    mem0[2] = DW'(-1);   mem0[3] = DW'(-4);   mem0[66] = DW'(-6);  mem0[67] = DW'(9);
    mem0[4] = DW'(100);  mem0[5] = DW'(-100); mem0[68] = DW'(3);   mem0[69] = DW'(99);
    mem0[6] = DW'(0);    mem0[7] = DW'(50);   mem0[70] = DW'(-7);  mem0[71] = DW'(49);
    run(30, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("win_w2_max", mem1[0], dw(12));
    check("win_w3_max", mem1[1], dw(9));
    check("win_w0_max", mem1[2], dw(100));
    check("win_w1_max", mem1[3], dw(50));

    // All-negative window: signed compare, optional clamp
    mem0[0] = DW'(-8); mem0[1] = DW'(-2); mem0[64] = DW'(-5); mem0[65] = DW'(-9);
    run(12, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef MAXPOOL_RELU_EN
    check("win_neg", mem1[0], dw(0));
`else
    check("win_neg", mem1[0], dw(-2));
`endif

    // Reset in the middle of a pass
    for (int a = 0; a < IMG_W * IMG_W; a++) mem0[a] = DW'(a);
    run(303, 0, 300);
    check("mid_rst_busy",  rst_busy, 0);
    check("mid_rst_rd",    rst_rd,   0);
    check("mid_rst_wr",    rst_wr,   0);
    check("mid_rst_done",  rst_done, 0);
    check("mid_rst_addr",  rst_addr, 0);
    check("mid_rst_nodone", done_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fresh pass after reset with a descending pattern
    for (int a = 0; a < IMG_W * IMG_W; a++) mem0[a] = DW'(IMG_W * IMG_W - 1 - a);
    run(PASS_CYC + 20, 0, 0);
    check("p3_first_addr", first_addr, 0);
    check("p3_addr_seq",   addr_err,   0);
    check("p3_done_at",    done_at,    6145);
    check("p3_done_once",  done_cnt,   1);
    check("p3_l1_0",       mem1[0],    dw(4095));
    check("p3_l1_33",      mem1[33],   dw(3965));
    check("p3_l1_1023",    mem1[1023], dw(65));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
